// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the instruction fetch/dispatch unit and its datapath.
package pc_sequencer_pkg;

  localparam int unsigned PC_W = 8;
  localparam int unsigned OP_W = 16;

  // Control-flow opcodes executed by the sequencer itself.
  localparam logic [3:0] OPC_HALT = 4'h0;
  localparam logic [3:0] OPC_JMP  = 4'hE;
  localparam logic [3:0] OPC_JNZ  = 4'hF;

  // Datapath opcodes; the sequencer forwards these untouched.
  localparam logic [3:0] OPC_MOV  = 4'h1;
  localparam logic [3:0] OPC_ADD  = 4'h2;
  localparam logic [3:0] OPC_SUB  = 4'h3;
  localparam logic [3:0] OPC_AND  = 4'h4;
  localparam logic [3:0] OPC_OR   = 4'h5;
  localparam logic [3:0] OPC_XOR  = 4'h6;
  localparam logic [3:0] OPC_CMP  = 4'h7;
  localparam logic [3:0] OPC_LD   = 4'h8;
  localparam logic [3:0] OPC_ST   = 4'h9;
  localparam logic [3:0] OPC_LDI  = 4'hA;
  localparam logic [3:0] OPC_SHL  = 4'hB;
  localparam logic [3:0] OPC_SHR  = 4'hC;
  localparam logic [3:0] OPC_TST  = 4'hD;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_EXEC,
    ST_ISSUE,
    ST_WAIT,
    ST_HALT
  } state_e;

  // True for opcodes the sequencer executes without the datapath.
  function automatic logic is_local_op(input logic [3:0] opc);
    return (opc == OPC_HALT) || (opc == OPC_JMP) || (opc == OPC_JNZ);
  endfunction

endpackage

// File: rtl/pc_sequencer_step_watchdog.sv
// Retired-instruction counter; flags the step that reaches STEP_LIMIT.
module step_watchdog #(
  parameter logic [15:0] STEP_LIMIT = 16'hFFFF
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);

  logic [15:0] count_q;

  // Count enabled steps, saturating at the limit; clear wins over enable.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else if (clear_i) begin
      count_q <= '0;
    end else if (en_i && (count_q != STEP_LIMIT)) begin
      count_q <= count_q + 16'd1;
    end
  end

  // Expired when the step being taken now is the STEP_LIMIT-th one.
  assign expired_o = en_i && (({1'b0, count_q} + 17'd1) >= {1'b0, STEP_LIMIT});

endmodule

// File: rtl/pc_sequencer.sv
// Instruction fetch and dispatch: runs control flow locally, issues the rest
// to the datapath over valid/ready and waits for done/flag.
module pc_sequencer #(
  parameter int unsigned PC_W       = pc_sequencer_pkg::PC_W,
  parameter int unsigned OP_W       = pc_sequencer_pkg::OP_W,
  parameter logic [15:0] STEP_LIMIT = 16'hFFFF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic [PC_W-1:0] pc,
  input  logic [OP_W-1:0] op,
  output logic            dp_valid,
  input  logic            dp_ready,
  output logic [3:0]      dp_opcode,
  output logic [11:0]     dp_fields,
  input  logic            dp_done,
  input  logic            dp_flag,
  output logic            busy,
  output logic            halted,
  output logic            err
);

  import pc_sequencer_pkg::*;

  state_e          state_q;
  logic [PC_W-1:0] pc_q;
  logic [OP_W-1:0] ir_q;
  logic            flag_q;
  logic            dp_valid_q;
  logic [3:0]      dp_opcode_q;
  logic [11:0]     dp_fields_q;
  logic            busy_q;
  logic            halted_q;
  logic            err_q;

  logic [3:0]      ir_opc;
  logic [PC_W-1:0] ir_tgt;
  logic            start_ok;
  logic            wd_en;
  logic            wd_expired;
  logic            pc_at_end;

  assign ir_opc    = ir_q[OP_W-1 -: 4];
  assign ir_tgt    = ir_q[PC_W-1:0];
  assign start_ok  = start && ((state_q == ST_IDLE) || (state_q == ST_HALT));
  assign wd_en     = (state_q == ST_EXEC);
  assign pc_at_end = &pc_q;

  step_watchdog #(
    .STEP_LIMIT(STEP_LIMIT)
  ) u_step_watchdog (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .clear_i  (start_ok),
    .en_i     (wd_en),
    .expired_o(wd_expired)
  );

  // Sequencer FSM with all outputs registered alongside the state.
  // Falling through pc 8'hFF (sequential advance) halts with err and leaves pc at FF.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      pc_q        <= '0;
      ir_q        <= '0;
      flag_q      <= 1'b0;
      dp_valid_q  <= 1'b0;
      dp_opcode_q <= '0;
      dp_fields_q <= '0;
      busy_q      <= 1'b0;
      halted_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_HALT: begin
          if (start_ok) begin
            pc_q     <= '0;
            flag_q   <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b1;
            halted_q <= 1'b0;
            state_q  <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          ir_q    <= op;
          state_q <= ST_EXEC;
        end
        ST_EXEC: begin
          if (wd_expired) begin
            err_q    <= 1'b1;
            busy_q   <= 1'b0;
            halted_q <= 1'b1;
            state_q  <= ST_HALT;
          end else if (!is_local_op(ir_opc)) begin
            dp_valid_q  <= 1'b1;
            dp_opcode_q <= ir_opc;
            dp_fields_q <= ir_q[11:0];
            state_q     <= ST_ISSUE;
          end else if (ir_opc == OPC_HALT) begin
            busy_q   <= 1'b0;
            halted_q <= 1'b1;
            state_q  <= ST_HALT;
          end else if ((ir_opc == OPC_JMP) || flag_q) begin
            pc_q    <= ir_tgt;
            state_q <= ST_FETCH;
          end else if (pc_at_end) begin
            err_q    <= 1'b1;
            busy_q   <= 1'b0;
            halted_q <= 1'b1;
            state_q  <= ST_HALT;
          end else begin
            pc_q    <= pc_q + PC_W'(1);
            state_q <= ST_FETCH;
          end
        end
        ST_ISSUE: begin
          if (dp_ready) begin
            dp_valid_q <= 1'b0;
            state_q    <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (dp_done) begin
            flag_q <= dp_flag;
            if (pc_at_end) begin
              err_q    <= 1'b1;
              busy_q   <= 1'b0;
              halted_q <= 1'b1;
              state_q  <= ST_HALT;
            end else begin
              pc_q    <= pc_q + PC_W'(1);
              state_q <= ST_FETCH;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign pc        = pc_q;
  assign dp_valid  = dp_valid_q;
  assign dp_opcode = dp_opcode_q;
  assign dp_fields = dp_fields_q;
  assign busy      = busy_q;
  assign halted    = halted_q;
  assign err       = err_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus random
// forward-branching programs checked against an instruction-level model.
`timescale 1ns/1ps
module tb_pc_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start, dp_ready, dp_done, dp_flag;
  logic [7:0]  pc;
  logic [15:0] op;
  logic        dp_valid, busy, halted, err;
  logic [3:0]  dp_opcode;
  logic [11:0] dp_fields;

  logic        start_w;
  logic [7:0]  pc_w;
  logic [15:0] op_w;
  logic        dpv_w, busy_w, halted_w, err_w;
  logic [3:0]  dpo_w;
  logic [11:0] dpf_w;

  logic [15:0] rom   [256];
  logic [15:0] rom_w [256];

  assign op   = rom[pc];
  assign op_w = rom_w[pc_w];

  pc_sequencer #(.PC_W(8), .OP_W(16), .STEP_LIMIT(16'hFFFF)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pc(pc), .op(op),
    .dp_valid(dp_valid), .dp_ready(dp_ready), .dp_opcode(dp_opcode),
    .dp_fields(dp_fields), .dp_done(dp_done), .dp_flag(dp_flag),
    .busy(busy), .halted(halted), .err(err)
  );

  pc_sequencer #(.PC_W(8), .OP_W(16), .STEP_LIMIT(16'd4)) dut_wd (
    .clk(clk), .rst_n(rst_n), .start(start_w), .pc(pc_w), .op(op_w),
    .dp_valid(dpv_w), .dp_ready(1'b0), .dp_opcode(dpo_w),
    .dp_fields(dpf_w), .dp_done(1'b0), .dp_flag(1'b0),
    .busy(busy_w), .halted(halted_w), .err(err_w)
  );

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  logic [7:0]  trace[$];
  logic [15:0] iss[$];
  logic        flags[$];
  int unsigned run_cycles, unstable, dv_cycles;
  bit          timed_out;

  logic [7:0]  exp_trace[$];
  logic [15:0] exp_iss[$];
  logic        exp_err;
  logic [7:0]  exp_pc;

  // Instruction-level interpreter of the program in rom, using the flags the
  // bench's datapath returned, in order.
  task automatic model_run(input int unsigned limit);
    int unsigned p = 0, steps = 0, fi = 0;
    logic f = 1'b0;
    logic [15:0] w;
    bit fin = 0;
    exp_trace.delete(); exp_iss.delete(); exp_err = 1'b0;
    while (!fin) begin
      if (exp_trace.size() == 0 || exp_trace[$] != 8'(p)) exp_trace.push_back(8'(p));
      w = rom[p];
      steps++;
      if (steps >= limit) begin exp_err = 1'b1; fin = 1; end
      else if (w[15:12] == 4'h0) fin = 1;
      else if (w[15:12] == 4'hE) p = int'(w[7:0]);
      else if (w[15:12] == 4'hF && f) p = int'(w[7:0]);
      else begin
        if (w[15:12] != 4'hF) begin
          exp_iss.push_back(w);
          f = (fi < flags.size()) ? flags[fi] : 1'b0;
          fi++;
        end
        if (p == 255) begin exp_err = 1'b1; fin = 1; end
        else p++;
      end
    end
    exp_pc = 8'(p);
  endtask

  task automatic clear_rom();
    for (int unsigned i = 0; i < 256; i++) rom[i] = 16'h0000;
  endtask

  // Start a run and act as the datapath until halted (or the cycle budget ends).
  // flag_mode: 0/1 force the returned flag, 2 random. noise adds ignored
  // start/dp_done pulses outside WAIT.
  task automatic run_dut(input int unsigned max_cyc, input int unsigned ready_pct,
                         input int unsigned hold_cyc, input int unsigned max_dly,
                         input int unsigned flag_mode, input bit noise);
    int unsigned dly = 0, hold_left;
    bit waiting = 0, holding = 0;
    logic [15:0] held = '0;
    logic f;
    hold_left = hold_cyc;
    trace.delete(); iss.delete(); flags.delete();
    unstable = 0; timed_out = 0; run_cycles = 0; dv_cycles = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    while (halted !== 1'b1) begin
      if (run_cycles >= max_cyc) begin timed_out = 1; break; end
      if (trace.size() == 0 || trace[$] != pc) trace.push_back(pc);
      if (dp_valid === 1'b1) begin
        dv_cycles++;
        if (holding && held != {dp_opcode, dp_fields}) unstable++;
        holding = 1;
        held = {dp_opcode, dp_fields};
      end else holding = 0;
      dp_done  = 1'b0;
      dp_ready = noise ? 1'($urandom) : 1'b0;
      dp_flag  = 1'($urandom);
      start    = noise && ($urandom_range(7) == 0);
      if (waiting) begin
        if (dly == 0) begin
          f = (flag_mode == 2) ? 1'($urandom) : 1'(flag_mode);
          dp_flag = f; dp_done = 1'b1; flags.push_back(f); waiting = 0;
        end else dly--;
      end else if (dp_valid === 1'b1) begin
        if (hold_left > 0) begin hold_left--; dp_ready = 1'b0; end
        else dp_ready = ($urandom_range(99) < ready_pct);
        if (dp_ready) begin
          iss.push_back({dp_opcode, dp_fields});
          waiting = 1; dly = $urandom_range(max_dly); hold_left = hold_cyc;
        end else if (noise) dp_done = 1'($urandom);
      end else if (noise) dp_done = 1'($urandom);
      @(negedge clk); run_cycles++;
    end
    if (trace.size() == 0 || trace[$] != pc) trace.push_back(pc);
    dp_done = 1'b0; dp_ready = 1'b0; start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; start_w = 1'b0;
    dp_ready = 1'b0; dp_done = 1'b0; dp_flag = 1'b0;
    clear_rom();
    for (int unsigned i = 0; i < 256; i++) rom_w[i] = 16'h0000;
    repeat (2) @(negedge clk);
    n_vec++; if ({pc, dp_valid, dp_opcode, dp_fields} !== 25'd0) begin
      n_bad++; $display("FAIL reset_dp: pc=%h v=%b opc=%h fld=%h, want all 0", pc, dp_valid, dp_opcode, dp_fields); end
    n_vec++; if ({busy, halted, err} !== 3'b000) begin
      n_bad++; $display("FAIL reset_status: busy=%b halted=%b err=%b, want 000", busy, halted, err); end
    n_vec++; if ({pc_w, dpv_w, dpo_w, dpf_w, busy_w, halted_w, err_w} !== 28'd0) begin
      n_bad++; $display("FAIL reset_wd: pc=%h v=%b opc=%h fld=%h st=%b%b%b, want all 0", pc_w, dpv_w, dpo_w, dpf_w, busy_w, halted_w, err_w); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_vec++; if ({busy, halted, pc} !== 10'd0) begin
      n_bad++; $display("FAIL idle_hold: busy=%b halted=%b pc=%h, want 0 0 00", busy, halted, pc); end
  endtask

  task automatic test_jmp_halt();
    clear_rom(); rom[0] = 16'hE005; rom[5] = 16'h0000;
    run_dut(50, 100, 0, 0, 0, 0);
    n_vec++; if (timed_out || trace.size() != 2 || trace[0] != 8'h00 || trace[1] != 8'h05) begin
      n_bad++; $display("FAIL jmp_trace: got %p (timeout=%0d), want 00 05", trace, timed_out); end
    n_vec++; if (run_cycles != 4) begin
      n_bad++; $display("FAIL jmp_halt_latency: halted after %0d cycles, want 4", run_cycles); end
    n_vec++; if (dv_cycles != 0) begin
      n_bad++; $display("FAIL jmp_no_issue: dp_valid seen %0d cycles, want 0", dv_cycles); end
    n_vec++; if ({halted, busy, err} !== 3'b100) begin
      n_bad++; $display("FAIL jmp_status: halted=%b busy=%b err=%b, want 1 0 0", halted, busy, err); end
  endtask

  task automatic test_dp_jnz_taken();
    clear_rom(); rom[0] = 16'h1120; rom[1] = 16'hF00A;
    run_dut(100, 100, 0, 0, 1, 0);
    n_vec++; if (iss.size() != 1 || iss[0] != 16'h1120) begin
      n_bad++; $display("FAIL issue_fields: got %p, want 1120", iss); end
    n_vec++; if (timed_out || trace.size() != 3 || trace[0] != 8'h00 || trace[1] != 8'h01 || trace[2] != 8'h0A) begin
      n_bad++; $display("FAIL jnz_taken_trace: got %p (timeout=%0d), want 00 01 0a", trace, timed_out); end
  endtask

  task automatic test_ready_stall();
    clear_rom(); rom[0] = 16'h1120; rom[1] = 16'hF00A;
    run_dut(100, 100, 3, 0, 0, 0);
    n_vec++; if (timed_out || trace.size() != 3 || trace[0] != 8'h00 || trace[1] != 8'h01 || trace[2] != 8'h02) begin
      n_bad++; $display("FAIL jnz_fall_trace: got %p (timeout=%0d), want 00 01 02", trace, timed_out); end
    n_vec++; if (dv_cycles != 4) begin
      n_bad++; $display("FAIL stall_valid_len: dp_valid held %0d cycles, want 4", dv_cycles); end
    n_vec++; if (unstable != 0 || iss.size() != 1 || iss[0] != 16'h1120) begin
      n_bad++; $display("FAIL stall_stable: %0d changes, issued %p, want 0 and 1120", unstable, iss); end
  endtask

  task automatic test_pc_wrap();
    clear_rom(); rom[0] = 16'hE0FF; rom[8'hFF] = 16'h3ABC;
    run_dut(200, 70, 0, 2, 2, 0);
    n_vec++; if (timed_out || {err, halted, busy} !== 3'b110 || pc !== 8'hFF) begin
      n_bad++; $display("FAIL wrap_dp: err=%b halted=%b busy=%b pc=%h, want 1 1 0 ff", err, halted, busy, pc); end
    n_vec++; if (iss.size() != 1 || iss[0] != 16'h3ABC) begin
      n_bad++; $display("FAIL wrap_dp_issue: got %p, want 3abc", iss); end
    rom[8'hFF] = 16'hF010;
    run_dut(200, 70, 0, 2, 2, 0);
    n_vec++; if (timed_out || {err, halted} !== 2'b11 || pc !== 8'hFF || iss.size() != 0) begin
      n_bad++; $display("FAIL wrap_jnz: err=%b halted=%b pc=%h issued=%0d, want 1 1 ff 0", err, halted, pc, iss.size()); end
  endtask

  task automatic test_watchdog();
    int unsigned c;
    rom_w[0] = 16'hE000;
    for (int unsigned run = 0; run < 2; run++) begin
      @(negedge clk); start_w = 1'b1;
      @(negedge clk); start_w = 1'b0;
      n_vec++; if ({err_w, busy_w, halted_w} !== 3'b010 || pc_w !== 8'h00) begin
        n_bad++; $display("FAIL wd_start%0d: err=%b busy=%b halted=%b pc=%h, want 0 1 0 00", run, err_w, busy_w, halted_w, pc_w); end
      c = 0;
      while (halted_w !== 1'b1 && c < 60) begin @(negedge clk); c++; end
      n_vec++; if (c != 8) begin
        n_bad++; $display("FAIL wd_latency%0d: halted after %0d cycles, want 8", run, c); end
      n_vec++; if ({err_w, halted_w, dpv_w} !== 3'b110 || pc_w !== 8'h00) begin
        n_bad++; $display("FAIL wd_expire%0d: err=%b halted=%b v=%b pc=%h, want 1 1 0 00", run, err_w, halted_w, dpv_w, pc_w); end
    end
  endtask

  task automatic test_reset_mid_run();
    int unsigned c;
    clear_rom(); rom[0] = 16'hE020; rom[8'h20] = 16'h2345;
    for (int unsigned phase = 0; phase < 2; phase++) begin
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      c = 0;
      while (dp_valid !== 1'b1 && c < 20) begin @(negedge clk); c++; end
      if (phase == 1) begin dp_ready = 1'b1; @(negedge clk); dp_ready = 1'b0; end
      n_vec++; if (busy !== 1'b1 || dp_opcode !== 4'h2 || dp_valid !== (phase == 0)) begin
        n_bad++; $display("FAIL mid_run_reach%0d: busy=%b v=%b opc=%h", phase, busy, dp_valid, dp_opcode); end
      #2 rst_n = 1'b0;
      #1;
      n_vec++; if ({pc, dp_valid, dp_opcode, dp_fields, busy, halted, err} !== 28'd0) begin
        n_bad++; $display("FAIL async_reset%0d: pc=%h v=%b opc=%h fld=%h st=%b%b%b, want all 0", phase, pc, dp_valid, dp_opcode, dp_fields, busy, halted, err); end
      @(negedge clk); rst_n = 1'b1;
    end
    dp_done = 1'b1; dp_flag = 1'b1;
    @(negedge clk); dp_done = 1'b0; dp_flag = 1'b0;
    @(negedge clk);
    n_vec++; if ({busy, halted, dp_valid} !== 3'b000 || pc !== 8'h00) begin
      n_bad++; $display("FAIL stray_done: busy=%b halted=%b v=%b pc=%h, want idle at 00", busy, halted, dp_valid, pc); end
    run_dut(100, 100, 0, 1, 0, 0);
    n_vec++; if (timed_out || trace.size() != 3 || trace[1] != 8'h20 || trace[2] != 8'h21 || iss.size() != 1 || iss[0] != 16'h2345) begin
      n_bad++; $display("FAIL post_reset_run: trace %p issued %p, want 00 20 21 / 2345", trace, iss); end
  endtask

  task automatic test_back_to_back();
    clear_rom(); rom[0] = 16'hF005; rom[1] = 16'h4321;
    for (int unsigned run = 0; run < 2; run++) begin
      run_dut(100, 100, 0, 0, 1, 0);
      n_vec++; if (timed_out || trace.size() != 3 || trace[0] != 8'h00 || trace[1] != 8'h01 || trace[2] != 8'h02 || iss.size() != 1) begin
        n_bad++; $display("FAIL restart_flag%0d: trace %p issued %0d, want 00 01 02 / 1", run, trace, iss.size()); end
    end
  endtask

  task automatic test_random_programs();
    int unsigned len, k;
    logic [7:0] tgt;
    for (int unsigned t = 0; t < 10; t++) begin
      clear_rom();
      len = $urandom_range(20, 8);
      for (int unsigned i = 0; i < len; i++) begin
        k   = $urandom_range(9);
        tgt = 8'($urandom_range(len, i + 1));
        if (k < 6)      rom[i] = {4'($urandom_range(13, 1)), 12'($urandom)};
        else if (k < 7) rom[i] = {4'hE, 4'($urandom), tgt};
        else if (k < 9) rom[i] = {4'hF, 4'($urandom), tgt};
        else            rom[i] = {4'h0, 12'($urandom)};
      end
      run_dut(3000, 60, 0, 3, 2, 1);
      model_run(65535);
      n_vec++; if (timed_out || trace.size() != exp_trace.size()) begin
        n_bad++; $display("FAIL rand%0d_trace_len: got %0d (timeout=%0d), want %0d", t, trace.size(), timed_out, exp_trace.size()); end
      for (int unsigned i = 0; i < trace.size() && i < exp_trace.size(); i++) begin
        n_vec++; if (trace[i] != exp_trace[i]) begin
          n_bad++; $display("FAIL rand%0d_pc[%0d]: got %h, want %h", t, i, trace[i], exp_trace[i]); end
      end
      n_vec++; if (iss.size() != exp_iss.size()) begin
        n_bad++; $display("FAIL rand%0d_issue_len: got %0d, want %0d", t, iss.size(), exp_iss.size()); end
      for (int unsigned i = 0; i < iss.size() && i < exp_iss.size(); i++) begin
        n_vec++; if (iss[i] != exp_iss[i]) begin
          n_bad++; $display("FAIL rand%0d_issue[%0d]: got %h, want %h", t, i, iss[i], exp_iss[i]); end
      end
      n_vec++; if (pc !== exp_pc || err !== exp_err || {halted, busy} !== 2'b10) begin
        n_bad++; $display("FAIL rand%0d_end: pc=%h err=%b halted=%b busy=%b, want %h %b 1 0", t, pc, err, halted, busy, exp_pc, exp_err); end
    end
  endtask

  initial begin
    test_reset();
    test_jmp_halt();
    test_dp_jnz_taken();
    test_ready_stall();
    test_pc_wrap();
    test_watchdog();
    test_reset_mid_run();
    test_back_to_back();
    test_random_programs();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
